adder_core: RTL and testbench



---
 rtl/adder_core.sv | 78 +++++++
 tb/tb_adder_core.sv | 131 +++++++++++++
 2 files changed

// File: rtl/adder_core.sv
// Unsigned adder with a registered, carry-extended sum (1-cycle latency).
// ARCHITECTURE selects behavioural, ripple-carry or 4-bit carry-lookahead slices.
module adder_core #(
  parameter string       ARCHITECTURE = "BEHAVIORAL",
  parameter int unsigned DATA_WIDTH_1 = 8,
  parameter int unsigned DATA_WIDTH_2 = 8
) (
  input  logic                                                              clk,
  input  logic                                                              rst,
  input  logic [DATA_WIDTH_1-1:0]                                           data1_i,
  input  logic [DATA_WIDTH_2-1:0]                                           data2_i,
  output logic [((DATA_WIDTH_1 > DATA_WIDTH_2) ? DATA_WIDTH_1 : DATA_WIDTH_2):0] data_o
);

  localparam int unsigned IN_WIDTH  = (DATA_WIDTH_1 > DATA_WIDTH_2) ? DATA_WIDTH_1 : DATA_WIDTH_2;
  localparam int unsigned OUT_WIDTH = IN_WIDTH + 1;
  localparam int unsigned NUM_GRPS  = (IN_WIDTH + 3) / 4;
  localparam int unsigned PAD_WIDTH = 4 * NUM_GRPS;

  logic [IN_WIDTH-1:0]  op_a;
  logic [IN_WIDTH-1:0]  op_b;
  logic [OUT_WIDTH-1:0] sum_c;

  assign op_a = IN_WIDTH'(data1_i);
  assign op_b = IN_WIDTH'(data2_i);

  // Carries c1..c4 of one 4-bit slice, each as a flat sum of products.
  function automatic logic [3:0] cla4(input logic [3:0] p, input logic [3:0] g, input logic cin);
    logic [3:0] c;
    logic       prod;
    c = '0;
    for (int k = 1; k <= 4; k++) begin
      prod = cin;
      for (int j = 0; j < k; j++) prod = prod & p[j];
      c[k-1] = prod;
      for (int j = 0; j < k; j++) begin
        prod = g[j];
        for (int m = j + 1; m < k; m++) prod = prod & p[m];
        c[k-1] = c[k-1] | prod;
      end
    end
    return c;
  endfunction

  if (ARCHITECTURE == "RIPPLE") begin : gen_ripple
    logic [IN_WIDTH:0]   carry;
    logic [IN_WIDTH-1:0] sum_bits;
    assign carry[0] = 1'b0;
    for (genvar i = 0; i < IN_WIDTH; i++) begin : gen_fa
      assign sum_bits[i] = op_a[i] ^ op_b[i] ^ carry[i];
      assign carry[i+1]  = (op_a[i] & op_b[i]) | (carry[i] & (op_a[i] ^ op_b[i]));
    end
    assign sum_c = {carry[IN_WIDTH], sum_bits};
  end else if (ARCHITECTURE == "CARRY_LOOKAHEAD") begin : gen_cla
    // Operands padded to whole slices; pad bits have p=g=0 so they never carry.
    logic [PAD_WIDTH-1:0] prop;
    logic [PAD_WIDTH-1:0] gen;
    logic [PAD_WIDTH:0]   carry;
    logic [PAD_WIDTH-1:0] sum_bits;
    assign prop     = PAD_WIDTH'(op_a ^ op_b);
    assign gen      = PAD_WIDTH'(op_a & op_b);
    assign carry[0] = 1'b0;
    for (genvar gi = 0; gi < NUM_GRPS; gi++) begin : gen_grp
      assign carry[4*gi+1 +: 4] = cla4(prop[4*gi +: 4], gen[4*gi +: 4], carry[4*gi]);
    end
    assign sum_bits = prop ^ carry[PAD_WIDTH-1:0];
    assign sum_c    = {carry[IN_WIDTH], sum_bits[IN_WIDTH-1:0]};
  end else begin : gen_behavioral
    assign sum_c = OUT_WIDTH'(op_a) + OUT_WIDTH'(op_b);
  end

  // Single output register; reset discards any in-flight sum.
  always_ff @(posedge clk) begin
    if (rst) data_o <= '0;
    else     data_o <= sum_c;
  end

endmodule

// File: tb/tb_adder_core.sv
// Self-checking bench for adder_core: all three architectures at widths 8/8, 16/5, 13/13
// run side by side against a queue-based reference; plus one default-architecture 8/4 instance.
module tb_adder_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [7:0]  a8, b8;
  logic [15:0] a16;
  logic [4:0]  b5;
  logic [12:0] a13, b13;
  logic [7:0]  a84;
  logic [3:0]  b4;

  logic [8:0]  o8_beh, o8_rip, o8_cla;
  logic [16:0] o16_beh, o16_rip, o16_cla;
  logic [13:0] o13_beh, o13_rip, o13_cla;
  logic [8:0]  o84;

  logic [8:0]  q8[$];
  logic [16:0] q16[$];
  logic [13:0] q13[$];
  logic [8:0]  q84[$];

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  adder_core #(.ARCHITECTURE("BEHAVIORAL"),      .DATA_WIDTH_1(8),  .DATA_WIDTH_2(8))  u_beh8  (.clk(clk), .rst(rst), .data1_i(a8),  .data2_i(b8),  .data_o(o8_beh));
  adder_core #(.ARCHITECTURE("RIPPLE"),          .DATA_WIDTH_1(8),  .DATA_WIDTH_2(8))  u_rip8  (.clk(clk), .rst(rst), .data1_i(a8),  .data2_i(b8),  .data_o(o8_rip));
  adder_core #(.ARCHITECTURE("CARRY_LOOKAHEAD"), .DATA_WIDTH_1(8),  .DATA_WIDTH_2(8))  u_cla8  (.clk(clk), .rst(rst), .data1_i(a8),  .data2_i(b8),  .data_o(o8_cla));
  adder_core #(.ARCHITECTURE("BEHAVIORAL"),      .DATA_WIDTH_1(16), .DATA_WIDTH_2(5))  u_beh16 (.clk(clk), .rst(rst), .data1_i(a16), .data2_i(b5),  .data_o(o16_beh));
  adder_core #(.ARCHITECTURE("RIPPLE"),          .DATA_WIDTH_1(16), .DATA_WIDTH_2(5))  u_rip16 (.clk(clk), .rst(rst), .data1_i(a16), .data2_i(b5),  .data_o(o16_rip));
  adder_core #(.ARCHITECTURE("CARRY_LOOKAHEAD"), .DATA_WIDTH_1(16), .DATA_WIDTH_2(5))  u_cla16 (.clk(clk), .rst(rst), .data1_i(a16), .data2_i(b5),  .data_o(o16_cla));
  adder_core #(.ARCHITECTURE("BEHAVIORAL"),      .DATA_WIDTH_1(13), .DATA_WIDTH_2(13)) u_beh13 (.clk(clk), .rst(rst), .data1_i(a13), .data2_i(b13), .data_o(o13_beh));
  adder_core #(.ARCHITECTURE("RIPPLE"),          .DATA_WIDTH_1(13), .DATA_WIDTH_2(13)) u_rip13 (.clk(clk), .rst(rst), .data1_i(a13), .data2_i(b13), .data_o(o13_rip));
  adder_core #(.ARCHITECTURE("CARRY_LOOKAHEAD"), .DATA_WIDTH_1(13), .DATA_WIDTH_2(13)) u_cla13 (.clk(clk), .rst(rst), .data1_i(a13), .data2_i(b13), .data_o(o13_cla));
  adder_core #(.DATA_WIDTH_1(8), .DATA_WIDTH_2(4))                                    u_def84 (.clk(clk), .rst(rst), .data1_i(a84), .data2_i(b4),  .data_o(o84));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rand_rest();
    a16 = 16'($urandom);
    b5  = 5'($urandom);
    a13 = 13'($urandom);
    b13 = 13'($urandom);
    a84 = 8'($urandom);
    b4  = 4'($urandom);
  endtask

  // Push expected sums for the current inputs, clock once, then pop and compare.
  task automatic step(input string tag);
    logic [8:0]  e8;
    logic [16:0] e16;
    logic [13:0] e13;
    logic [8:0]  e84;
    q8.push_back(rst ? 9'd0 : 9'(a8) + 9'(b8));
    q16.push_back(rst ? 17'd0 : 17'(a16) + 17'(b5));
    q13.push_back(rst ? 14'd0 : 14'(a13) + 14'(b13));
    q84.push_back(rst ? 9'd0 : 9'(a84) + 9'(b4));
    @(posedge clk);
    #1;
    e8  = q8.pop_front();
    e16 = q16.pop_front();
    e13 = q13.pop_front();
    e84 = q84.pop_front();
    check({tag, "/beh8"},   32'(o8_beh),  32'(e8));
    check({tag, "/rip8"},   32'(o8_rip),  32'(e8));
    check({tag, "/cla8"},   32'(o8_cla),  32'(e8));
    check({tag, "/beh16"},  32'(o16_beh), 32'(e16));
    check({tag, "/rip16"},  32'(o16_rip), 32'(e16));
    check({tag, "/cla16"},  32'(o16_cla), 32'(e16));
    check({tag, "/beh13"},  32'(o13_beh), 32'(e13));
    check({tag, "/rip13"},  32'(o13_rip), 32'(e13));
    check({tag, "/cla13"},  32'(o13_cla), 32'(e13));
    check({tag, "/def84"},  32'(o84),     32'(e84));
  endtask

  logic [7:0] dir_a[7] = '{8'h03, 8'h03, 8'h09, 8'hFF, 8'hFF, 8'h00, 8'h80};
  logic [7:0] dir_b[7] = '{8'h02, 8'h09, 8'h09, 8'hFF, 8'h01, 8'h00, 8'h80};

  initial begin
    // Reset held two edges with live operands, then released.
    rst = 1'b1; a8 = 8'h03; b8 = 8'h02; rand_rest();
    step("reset0");
    rand_rest();
    step("reset1");
    check("reset_value", 32'(o8_beh), 32'h0);
    rst = 1'b0; rand_rest();
    step("release");
    check("first_sum", 32'(o8_beh), 32'h005);

    // Back-to-back stream followed by carry boundaries.
    for (int i = 0; i < 7; i++) begin
      a8 = dir_a[i]; b8 = dir_b[i]; rand_rest();
      step($sformatf("dir%0d", i));
    end

    // Unequal widths on the 8/4 instance.
    rand_rest(); a84 = 8'hFF; b4 = 4'hF;
    step("uneq_max");
    check("uneq_max_abs", 32'(o84), 32'h10E);
    rand_rest(); a84 = 8'h00; b4 = 4'hF;
    step("uneq_zero");

    // Reset lands on the same edge as 0x10+0x20; 0x030 must never surface.
    a8 = 8'h10; b8 = 8'h20; rst = 1'b1; rand_rest();
    step("mid_rst");
    rst = 1'b0; a8 = 8'h01; b8 = 8'h01; rand_rest();
    step("mid_release");
    check("mid_release_abs", 32'(o8_cla), 32'h002);

    // Exhaustive 8/8 sweep; the other widths get fresh random pairs every cycle.
    for (int i = 0; i < 65536; i++) begin
      a8 = 8'(i >> 8);
      b8 = 8'(i);
      rand_rest();
      step("sweep");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
